// File: rtl/bram_stream_reader_pkg.sv
// ============================================================================
// Package     : bram_stream_pkg
// Description : Shared definitions for the BRAM stream reader. It holds the
//               FSM state encodings, the BRAM word size and a byte-to-word
//               count helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_stream_pkg;

    localparam int WORD_BYTES = 4;

    // Reader FSM state encodings.
    typedef logic [1:0] state_t;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // Converts a byte count to a whole-word count. Any trailing partial word
    // is dropped.
    function automatic logic [31:0] bytes_to_words(input logic [31:0] nbytes);
        return nbytes / 32'(WORD_BYTES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_stream_reader_if.sv
// ============================================================================
// Interface   : bram_stream_reader_if
// Description : AXI4-Stream data channel with tdata, tvalid, tready and
//               tlast.
//               master modport : drives tdata/tvalid/tlast, samples tready
//               slave  modport : samples tdata/tvalid/tlast, drives tready
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_stream_reader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/bram_stream_reader_skid_fifo2.sv
// ============================================================================
// Module      : skid_fifo2
// Description : Two-entry FIFO that acts as a skid buffer. Each entry holds
//               data plus a last flag. Slot 0 is always the head, so the head
//               outputs stay stable until a pop.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               push, push_data,
//               push_last          - write side; caller never pushes when full
//               pop                - remove head; caller never pops when empty
//               count              - occupancy, 0..2
//               head_data,
//               head_last          - current head entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              last0_q, last0_d, last1_q, last1_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    data0_d = push_data;
                    last0_d = push_last;
                end else begin
                    data1_d = push_data;
                    last1_d = push_last;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // The occupancy is unchanged. The new entry lands behind
                // whatever remains after the pop.
                if (count_q == 2'd2) begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = push_data;
                    last1_d = push_last;
                end else begin
                    data0_d = push_data;
                    last0_d = push_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = data0_q;
    assign head_last = last0_q;

endmodule

`default_nettype wire

// File: rtl/bram_stream_reader.sv
// ============================================================================
// Module      : bram_stream_reader
// Description : Drains num_of_inp bytes from a BRAM read port and emits them
//               as 32-bit words on an AXI4-Stream master. tlast is set on the
//               final word. done pulses for one cycle after the last beat is
//               accepted.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               start, num_of_inp  - transfer request and byte count
//               busy, done         - status; busy is high while streaming
//               bram_addr, bram_en,
//               bram_we, bram_dout - BRAM read port with 1-cycle read latency
//               m_axis             - stream master (bram_stream_reader_if)
// Options     : BRAM_STREAM_READER_STATS_EN adds the stall_cycles output. It
//               counts the cycles of the current transfer where tvalid is
//               high and tready is low, and saturates at 0xFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              CNT_W     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_of_inp,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    input  logic [DATA_W-1:0] bram_dout,
    bram_stream_reader_if.master m_axis
`ifdef BRAM_STREAM_READER_STATS_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int IDX_W = CNT_W - 2;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] words_q, words_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             in_flight_q, in_flight_d;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic              tvalid;
    logic              push;
    logic              pop;
    logic              push_last;
    logic              rd_issue;
    logic              start_ok;
    logic [2:0]        occupancy;
    logic [IDX_W-1:0]  words_in;

    assign start_ok  = (state_q == S_IDLE) && start;
    assign words_in  = IDX_W'(bytes_to_words(32'(num_of_inp)));
    assign tvalid    = (fifo_count != 2'd0);
    assign pop       = tvalid && m_axis.tready;
    assign push      = in_flight_q;
    assign push_last = (wr_idx_q == words_q - IDX_W'(1));

    // Read credit counts the entries in the FIFO plus the read in flight. The
    // slot freed by this cycle's pop is returned to the credit at once. This
    // sustains one beat per cycle and still never lets more than two words
    // be owed to the FIFO.
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, pop};
    assign rd_issue  = (state_q == S_RUN) && (rd_idx_q < words_q) && (occupancy < 3'd2);

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        rd_idx_d    = rd_idx_q;
        in_flight_d = rd_issue;
        wr_idx_d    = push ? (wr_idx_q + IDX_W'(1)) : wr_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_d     = words_in;
                    rd_idx_d    = '0;
                    wr_idx_d    = '0;
                    in_flight_d = 1'b0;
                    state_d     = (words_in == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (rd_issue) begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
                if (pop && head_last) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            words_q     <= '0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            in_flight_q <= in_flight_d;
        end
    end

    skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bram_dout),
        .push_last (push_last),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_FINISH);
    assign bram_en   = rd_issue;
    assign bram_addr = BASE_ADDR + ADDR_W'({rd_idx_q, 2'b00});
    assign bram_we   = 4'b0000;

    assign m_axis.tdata  = head_data;
    assign m_axis.tvalid = tvalid;
    assign m_axis.tlast  = tvalid && head_last;

`ifdef BRAM_STREAM_READER_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = 16'd0;
        end else if ((state_q == S_RUN) && tvalid && !m_axis.tready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Scoreboard bench for bram_stream_reader. Directed transfers
//               push the expected beats into a queue. A negedge monitor pops
//               and compares each accepted beat, checks hold-while-stalled
//               and done timing, and counts BRAM reads.
//               Honours BRAM_STREAM_READER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_stream_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 10;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_of_inp = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [DATA_W-1:0] bram_dout = '0;
`ifdef BRAM_STREAM_READER_STATS_EN
    logic [15:0]       stall_cycles;
`endif

    bram_stream_reader_if #(.DATA_W(DATA_W)) m_axis ();

    bram_stream_reader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .BASE_ADDR ('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_of_inp (num_of_inp),
        .busy       (busy),
        .done       (done),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_dout  (bram_dout),
        .m_axis     (m_axis)
`ifdef BRAM_STREAM_READER_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model: word i holds 4*i scaled by a gain of 5, and reads return
    // one cycle after bram_en.
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(20 * i);
    end
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr[9:2]];
    end

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // tready driver
    logic rand_mode = 1'b0;
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor and scoreboard
    int          done_cnt = 0;
    int          en_cnt = 0;
    int          valid_cnt = 0;
    int          stall_meas = 0;
    int          hs_total = 0;
    int          hs_mark = 0;
    int          first_hs_cyc = 0;
    int          last_hs_cyc = 0;
    logic [31:0] last_addr = '0;
    logic        exp_done = 1'b0;
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    initial forever begin
        beat_t e;
        @(negedge clk);
        if (!rst_n) begin
            prev_stalled = 1'b0;
            exp_done     = 1'b0;
        end else begin
            if (exp_done) begin
                check("done_after_last", 64'(done), 64'(1));
                check("busy_low_at_done", 64'(busy), 64'(0));
                exp_done = 1'b0;
            end
            if (done) done_cnt++;
            if (bram_en) begin
                en_cnt++;
                last_addr = bram_addr;
            end
            if (prev_stalled) begin
                check("stall_hold_valid", 64'(m_axis.tvalid), 64'(1));
                check("stall_hold_data", 64'(m_axis.tdata), 64'(prev_data));
                check("stall_hold_last", 64'(m_axis.tlast), 64'(prev_last));
            end
            if (m_axis.tvalid) valid_cnt++;
            if (m_axis.tvalid && !m_axis.tready) begin
                stall_meas++;
                prev_stalled = 1'b1;
                prev_data    = m_axis.tdata;
                prev_last    = m_axis.tlast;
            end else begin
                prev_stalled = 1'b0;
            end
            if (m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data 0x%0h, want no beat", m_axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_axis.tdata), 64'(e.data));
                    check("beat_last", 64'(m_axis.tlast), 64'(e.last));
                end
                if (hs_total == hs_mark) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_total++;
                if (m_axis.tlast) exp_done = 1'b1;
            end
        end
    end

    task automatic load_exp(input int words);
        for (int i = 0; i < words; i++) begin
            exp_q.push_back({32'(20 * i), (i == words - 1)});
        end
    endtask

    task automatic start_xfer(input int nbytes);
        @(posedge clk);
        #1;
        hs_mark    = hs_total;
        start      = 1'b1;
        num_of_inp = CNT_W'(nbytes);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (hs_total < hs_mark + n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (hs_total < hs_mark + n) begin
            total++;
            bad++;
            $display("FAIL wait_beats: got %0d beats, want %0d", hs_total - hs_mark, n);
        end
    endtask

    task automatic wait_done(input string name, input int base);
        int k = 0;
        while (done_cnt == base && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == base) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done, want done", name);
        end
        repeat (5) @(posedge clk);
        #1;
        check({name, "_single_done"}, 64'(done_cnt), 64'(base + 1));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_done"}, 64'(done), 64'(0));
        check({name, "_en"}, 64'(bram_en), 64'(0));
        check({name, "_addr"}, 64'(bram_addr), 64'(0));
        check({name, "_tvalid"}, 64'(m_axis.tvalid), 64'(0));
        check({name, "_tlast"}, 64'(m_axis.tlast), 64'(0));
        check({name, "_tdata"}, 64'(m_axis.tdata), 64'(0));
    endtask

    initial begin
        int base;
        int en_base;
        int v_base;
        int st_base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: 10 words with tready held high, checking latency and back-to-back beats
        load_exp(10);
        base = done_cnt;
        start_xfer(40);
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_tvalid_n1", 64'(m_axis.tvalid), 64'(0));
        @(posedge clk);
        #1;
        check("t1_tvalid_n2", 64'(m_axis.tvalid), 64'(0));
        @(posedge clk);
        #1;
        check("t1_first_beat_valid", 64'(m_axis.tvalid), 64'(1));
        check("t1_first_beat_data", 64'(m_axis.tdata), 64'(0));
        wait_done("t1", base);
        check("t1_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'(9));
        check("t1_we", 64'(bram_we), 64'(0));

        // 2: same data with random backpressure
        rand_mode = 1'b1;
        load_exp(10);
        base    = done_cnt;
        st_base = stall_meas;
        start_xfer(40);
        wait_done("t2", base);
`ifdef BRAM_STREAM_READER_STATS_EN
        check("t2_stall_cycles", 64'(stall_cycles), 64'(stall_meas - st_base));
`else
        st_base = stall_meas - st_base;
`endif
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);

        // 3: zero-length transfer
        base    = done_cnt;
        en_base = en_cnt;
        v_base  = valid_cnt;
        start_xfer(0);
        check("t3_done", 64'(done), 64'(1));
        check("t3_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check("t3_done_pulse", 64'(done), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_reads", 64'(en_cnt - en_base), 64'(0));
        check("t3_no_valid", 64'(valid_cnt - v_base), 64'(0));
        check("t3_single_done", 64'(done_cnt), 64'(base + 1));

        // 4: a start re-asserted at beat 3 is ignored
        load_exp(10);
        base = done_cnt;
        start_xfer(40);
        wait_beats(3);
        @(posedge clk);
        #1;
        start      = 1'b1;
        num_of_inp = CNT_W'(8);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4", base);
        repeat (15) @(posedge clk);
        #1;
        check("t4_beats", 64'(hs_total - hs_mark), 64'(10));

        // 5: reset at beat 5, then a 2-word transfer
        load_exp(10);
        start_xfer(40);
        wait_beats(5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        exp_q.delete();
        base = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        load_exp(2);
        start_xfer(8);
        wait_done("t5", base);
        check("t5_beats", 64'(hs_total - hs_mark), 64'(2));

        // 6: maximum length of 255 words
        load_exp(255);
        base    = done_cnt;
        en_base = en_cnt;
        start_xfer(1020);
        wait_done("t6", base);
        check("t6_last_addr", 64'(last_addr), 64'(32'h3F8));
        check("t6_reads", 64'(en_cnt - en_base), 64'(255));
        check("t6_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'(254));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
